// File: rtl/lc3_fetch_decode_in_src_pkg.sv
// Shared LC-3 fetch definitions: widths, reset PC and fetch FSM states.
// No logic, no latency, no backpressure.
package lc3_fetch_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [PC_W-1:0] PC_RESET_DEFAULT = 16'h3000;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_PRESENT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/lc3_fetch_decode_in_src_if.sv
// decode_in bus between fetch (master) and decode (slave).
// stall from decode holds the presented instruction in place.
interface lc3_fetch_decode_in_src_if;
  import lc3_fetch_pkg::*;

  logic [INSTR_W-1:0] Instr_dout;
  logic [PC_W-1:0]    npc_in;
  logic               enable_decode;
  logic               stall;

  modport master (
    output Instr_dout,
    output npc_in,
    output enable_decode,
    input  stall
  );

  modport slave (
    input  Instr_dout,
    input  npc_in,
    input  enable_decode,
    output stall
  );

endinterface

// File: rtl/lc3_fetch_decode_in_src_pc_unit.sv
// PC register with +1 incrementer and next-pc mux (taddr / npc / hold).
// One-cycle update; load_taddr wins over load_npc, neither means hold.
module lc3_pc_unit
  import lc3_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_taddr,
  input  logic            load_npc,
  input  logic [PC_W-1:0] taddr,
  input  logic [PC_W-1:0] npc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_inc
);

  // Wraps modulo 2^16: 16'hFFFF + 1 -> 16'h0000.
  assign pc_inc = pc + PC_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= PC_RESET;
    end else if (load_taddr) begin
      pc <= taddr;
    end else if (load_npc) begin
      pc <= npc;
    end
  end

endmodule

// File: rtl/lc3_fetch_decode_in_src.sv
// LC-3 fetch: one outstanding imem read, instruction presented to decode until consumed (3 cycles/instr at 1-cycle memory).
// decode stall holds PRESENT; br_taken redirects and squashes. FETCH_PERF_CNT_EN adds instr/squash counters.
module lc3_fetch_decode_in_src
  import lc3_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_fetch,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    taddr,
  output logic               imem_rd,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_dout,
  input  logic               imem_valid,
  lc3_fetch_decode_in_src_if.master dec
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        instr_count,
  output logic [15:0]        squash_count
`endif
);

  fetch_state_e       state, state_nxt;
  logic               drop, drop_nxt;
  logic               latch;
  logic               consume;
  logic [PC_W-1:0]    pc, pc_inc;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    npc_q;

  lc3_pc_unit #(.PC_RESET(PC_RESET)) u_pc (
    .clock      (clock),
    .reset      (reset),
    .load_taddr (br_taken),
    .load_npc   (consume),
    .taddr      (taddr),
    .npc        (npc_q),
    .pc         (pc),
    .pc_inc     (pc_inc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH_IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
    end
  end

  // A redirect in IDLE takes priority over fetching from the stale pc.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    imem_rd   = 1'b0;
    latch     = 1'b0;
    consume   = 1'b0;
    unique case (state)
      FETCH_IDLE: begin
        if (enable_fetch && !br_taken && !reset) begin
          imem_rd   = 1'b1;
          drop_nxt  = 1'b0;
          state_nxt = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_valid) begin
          latch     = !drop && !br_taken;
          drop_nxt  = 1'b0;
          state_nxt = (drop || br_taken) ? FETCH_IDLE : FETCH_PRESENT;
        end else if (br_taken) begin
          drop_nxt = 1'b1;
        end
      end
      FETCH_PRESENT: begin
        if (br_taken) begin
          state_nxt = FETCH_IDLE;
        end else if (!dec.stall) begin
          consume   = !reset;
          state_nxt = FETCH_IDLE;
        end
      end
      default: begin
        state_nxt = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q <= '0;
      npc_q   <= '0;
    end else if (latch) begin
      instr_q <= imem_dout;
      npc_q   <= pc_inc;
    end
  end

  assign imem_addr         = pc;
  assign dec.Instr_dout    = instr_q;
  assign dec.npc_in        = npc_q;
  assign dec.enable_decode = consume;

`ifdef FETCH_PERF_CNT_EN
  logic squash;
  assign squash = br_taken && (state != FETCH_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_count  <= '0;
      squash_count <= '0;
    end else begin
      if (consume) begin
        instr_count <= instr_count + 32'd1;
      end
      if (squash && (squash_count != 16'hFFFF)) begin
        squash_count <= squash_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lc3_fetch_decode_in_src.sv
// Bench for lc3_fetch_decode_in_src: directed scenarios with literal expectations, then randomized traffic
// against a transaction-level model with a variable-latency memory responder.
module tb_lc3_fetch_decode_in_src;
  import lc3_fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset, enable_fetch, br_taken, imem_rd, imem_valid;
  logic [15:0] taddr, imem_addr, imem_dout;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_count;
  logic [15:0] squash_count;
`endif

  always #5 clock = ~clock;

  lc3_fetch_decode_in_src_if dec ();

  lc3_fetch_decode_in_src dut (
    .clock        (clock),
    .reset        (reset),
    .enable_fetch (enable_fetch),
    .br_taken     (br_taken),
    .taddr        (taddr),
    .imem_rd      (imem_rd),
    .imem_addr    (imem_addr),
    .imem_dout    (imem_dout),
    .imem_valid   (imem_valid),
    .dec          (dec.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .instr_count  (instr_count),
    .squash_count (squash_count)
`endif
  );

  int checks = 0;
  int passed = 0;

  // Model: pc, whether a read is outstanding (and doomed), and the instruction on offer.
  bit          m_ok = 1'b0;
  bit          m_busy, m_drop, m_have;
  logic [15:0] m_pc, m_instr, m_npc;
  logic [31:0] m_ic;
  logic [15:0] m_sq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input bit r, input bit ef, input bit st, input bit br,
                      input logic [15:0] ta, input bit iv, input logic [15:0] id,
                      output bit issued);
    bit          exp_rd, exp_ed;
    logic [15:0] old_pc;
    @(negedge clock);
    reset = r; enable_fetch = ef; dec.stall = st; br_taken = br;
    taddr = ta; imem_valid = iv; imem_dout = id;
    #1;
    exp_rd = !r && !m_busy && !m_have && ef && !br;
    exp_ed = !r && m_have && !st && !br;
    issued = exp_rd;
    if (m_ok) begin
      chk("imem_rd", {31'd0, imem_rd}, {31'd0, exp_rd});
      if (exp_rd) chk("imem_addr", {16'd0, imem_addr}, {16'd0, m_pc});
      chk("enable_decode", {31'd0, dec.enable_decode}, {31'd0, exp_ed});
      chk("Instr_dout", {16'd0, dec.Instr_dout}, {16'd0, m_instr});
      chk("npc_in", {16'd0, dec.npc_in}, {16'd0, m_npc});
`ifdef FETCH_PERF_CNT_EN
      chk("instr_count", instr_count, m_ic);
      chk("squash_count", {16'd0, squash_count}, {16'd0, m_sq});
`endif
    end
    if (r) begin
      m_ok = 1'b1; m_pc = 16'h3000; m_busy = 0; m_drop = 0; m_have = 0;
      m_instr = 16'h0; m_npc = 16'h0; m_ic = 0; m_sq = 0;
    end else begin
      old_pc = m_pc;
      if (br && (m_busy || m_have) && m_sq != 16'hFFFF) m_sq = m_sq + 16'd1;
      if (exp_ed) m_ic = m_ic + 32'd1;
      if (br) m_pc = ta;
      if (exp_rd) begin
        m_busy = 1; m_drop = 0;
      end else if (m_busy) begin
        if (iv) begin
          m_busy = 0;
          if (!m_drop && !br) begin
            m_have = 1; m_instr = id; m_npc = old_pc + 16'd1;
          end
          m_drop = 0;
        end else if (br) begin
          m_drop = 1;
        end
      end else if (m_have) begin
        if (exp_ed) m_pc = m_npc;
        if (br || !st) m_have = 0;
      end
    end
  endtask

  initial begin
    bit          d, iv, issued, mem_pending;
    int          mem_cnt;
    logic [15:0] id, mem_data;

    reset = 1; enable_fetch = 0; dec.stall = 0; br_taken = 0;
    taddr = 0; imem_valid = 0; imem_dout = 0;

    step(1, 0, 0, 0, 0, 0, 0, d);
    step(1, 0, 0, 0, 0, 0, 0, d);
    chk("rst_ed", {31'd0, dec.enable_decode}, 32'd0);
    chk("rst_instr", {16'd0, dec.Instr_dout}, 32'h0);
    chk("rst_npc", {16'd0, dec.npc_in}, 32'h0);

    // Basic fetch with 1-cycle memory.
    step(0, 1, 0, 0, 0, 0, 0, d);
    chk("t1_rd", {31'd0, imem_rd}, 32'd1);
    chk("t1_addr", {16'd0, imem_addr}, 32'h3000);
    step(0, 0, 0, 0, 0, 1, 16'h1234, d);
    step(0, 0, 0, 0, 0, 0, 0, d);
    chk("t1_ed", {31'd0, dec.enable_decode}, 32'd1);
    chk("t1_instr", {16'd0, dec.Instr_dout}, 32'h1234);
    chk("t1_npc", {16'd0, dec.npc_in}, 32'h3001);
    step(0, 0, 0, 0, 0, 0, 0, d);
    chk("t1_ed_once", {31'd0, dec.enable_decode}, 32'd0);

    // Stall holds the presented instruction.
    step(0, 1, 0, 0, 0, 0, 0, d);
    chk("t2_addr0", {16'd0, imem_addr}, 32'h3001);
    step(0, 0, 0, 0, 0, 1, 16'h5678, d);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0, 0, 0, d);
      chk("t2_stall_ed", {31'd0, dec.enable_decode}, 32'd0);
      chk("t2_stall_instr", {16'd0, dec.Instr_dout}, 32'h5678);
    end
    step(0, 0, 0, 0, 0, 0, 0, d);
    chk("t2_ed", {31'd0, dec.enable_decode}, 32'd1);
    step(0, 1, 0, 0, 0, 0, 0, d);
    chk("t2_addr", {16'd0, imem_addr}, 32'h3002);

    // Redirect during WAIT drops the response.
    step(0, 0, 0, 1, 16'h4000, 0, 0, d);
    step(0, 0, 0, 0, 0, 1, 16'hDEAD, d);
    step(0, 0, 0, 0, 0, 0, 0, d);
    chk("t3_ed", {31'd0, dec.enable_decode}, 32'd0);
    step(0, 1, 0, 0, 0, 0, 0, d);
    chk("t3_addr", {16'd0, imem_addr}, 32'h4000);

    // Redirect during PRESENT squashes.
    step(0, 0, 0, 0, 0, 1, 16'hBEEF, d);
    step(0, 0, 0, 1, 16'h5000, 0, 0, d);
    chk("t4_ed", {31'd0, dec.enable_decode}, 32'd0);
    step(0, 1, 0, 0, 0, 0, 0, d);
    chk("t4_addr", {16'd0, imem_addr}, 32'h5000);
`ifdef FETCH_PERF_CNT_EN
    chk("t4_sq", {16'd0, squash_count}, 32'd2);
`endif

    // PC wrap at 16'hFFFF.
    step(0, 0, 0, 1, 16'hFFFF, 0, 0, d);
    step(0, 0, 0, 0, 0, 1, 16'h0000, d);
    step(0, 1, 0, 0, 0, 0, 0, d);
    chk("t5_addr", {16'd0, imem_addr}, 32'hFFFF);
    step(0, 0, 0, 0, 0, 1, 16'h1111, d);
    step(0, 0, 0, 0, 0, 0, 0, d);
    chk("t5_ed", {31'd0, dec.enable_decode}, 32'd1);
    chk("t5_npc", {16'd0, dec.npc_in}, 32'h0000);
    step(0, 1, 0, 0, 0, 0, 0, d);
    chk("t5_addr2", {16'd0, imem_addr}, 32'h0000);

    // Reset in WAIT; late response is ignored.
    step(1, 0, 0, 0, 0, 0, 0, d);
    step(0, 0, 0, 0, 0, 0, 0, d);
    step(0, 0, 0, 0, 0, 1, 16'h2222, d);
    step(0, 0, 0, 0, 0, 0, 0, d);
    chk("t6_ed", {31'd0, dec.enable_decode}, 32'd0);
    chk("t6_instr", {16'd0, dec.Instr_dout}, 32'h0);
    chk("t6_npc", {16'd0, dec.npc_in}, 32'h0);
    step(0, 1, 0, 0, 0, 0, 0, d);
    chk("t6_addr", {16'd0, imem_addr}, 32'h3000);

    // Randomized traffic; memory answers each read after 1..3 cycles.
    step(1, 0, 0, 0, 0, 0, 0, d);
    mem_pending = 0; mem_cnt = 0; mem_data = 0;
    for (int c = 0; c < 4000; c++) begin
      iv = 0; id = 16'($urandom);
      if (mem_pending) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          iv = 1; id = mem_data; mem_pending = 0;
        end
      end else if (!m_busy && $urandom_range(15) == 0) begin
        iv = 1;
      end
      step($urandom_range(63) == 0,
           ($urandom_range(9) < 7) && !mem_pending,
           $urandom_range(9) < 3,
           $urandom_range(9) == 0,
           16'($urandom), iv, id, issued);
      if (issued) begin
        mem_pending = 1;
        mem_cnt = $urandom_range(3, 1);
        mem_data = 16'($urandom);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
